// File: rtl/register_mode_pkg.sv
// Shared types for the RegisterMode configuration controller:
// FSM states, address field codes and mode encodings.
package register_mode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] FLD_MODE  = 2'd0;
  localparam logic [1:0] FLD_CONST = 2'd1;
  localparam logic [1:0] FLD_VALUE = 2'd2;
  localparam logic [1:0] FLD_RSVD  = 2'd3;

  localparam logic [1:0] MODE_CONST  = 2'h0;
  localparam logic [1:0] MODE_VALUE  = 2'h1;
  localparam logic [1:0] MODE_BYPASS = 2'h2;
  localparam logic [1:0] MODE_DELAY  = 2'h3;

endpackage

// File: rtl/register_mode_cfg_ctrl_decode.sv
// Splits a config address into slice select and field,
// flagging slice indices beyond the populated bank.
module register_mode_cfg_decode
  import register_mode_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W+1:0]    addr,
  output logic [1:0]          field,
  output logic                inRange,
  output logic [NUM_REGS-1:0] sel
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    idx     = addr[IDX_W+1:2];
    field   = addr[1:0];
    inRange = {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    sel     = '0;
    for (int i = 0; i < NUM_REGS; i++)
      sel[i] = (idx == IDX_W'(i));
  end

endmodule

// File: rtl/register_mode_cfg_ctrl.sv
// Config-bus sequencer for a bank of RegisterMode slices:
// holds mode/const_, pulses register writes, answers reads.
module register_mode_cfg_ctrl
  import register_mode_pkg::*;
#(
  parameter int         NUM_REGS   = 4,
  parameter int         WIDTH      = 4,
  parameter logic [1:0] MODE_RESET = MODE_CONST,
  localparam int        IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESET,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_write,
  input  logic [IDX_W+1:0]          cfg_addr,
  input  logic [WIDTH-1:0]          cfg_wdata,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      cfg_err,
  output logic [2*NUM_REGS-1:0]     mode,
  output logic [WIDTH*NUM_REGS-1:0] const_,
  output logic [NUM_REGS-1:0]       config_we,
  output logic [WIDTH-1:0]          config_data,
  input  logic [WIDTH*NUM_REGS-1:0] slice_value
);

  state_t              state, stateNxt;
  logic [1:0]          field;
  logic                inRange;
  logic [NUM_REGS-1:0] sel;
  logic [NUM_REGS-1:0] rdSel;
  logic [1:0]          rdField;
  logic                rdInRange;
  logic [WIDTH-1:0]    rdMux;
  logic                accept;

  register_mode_cfg_decode #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W)
  ) u_decode (
    .addr   (cfg_addr),
    .field  (field),
    .inRange(inRange),
    .sel    (sel)
  );

  assign cfg_ready = (state == IDLE);
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) state <= IDLE;
    else            state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: if (cfg_valid) stateNxt = cfg_write ? WR : RD;
      WR:   stateNxt = IDLE;
      RD:   stateNxt = RESP;
      RESP: stateNxt = IDLE;
    endcase
  end

  // Read data is taken in the RD cycle so slice_value is sampled at T+1
  always_comb begin
    rdMux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rdInRange && rdSel[i]) begin
        unique case (rdField)
          FLD_MODE:  rdMux = WIDTH'(mode[2*i +: 2]);
          FLD_CONST: rdMux = const_[WIDTH*i +: WIDTH];
          FLD_VALUE: rdMux = slice_value[WIDTH*i +: WIDTH];
          FLD_RSVD:  rdMux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      mode        <= {NUM_REGS{MODE_RESET}};
      const_      <= '0;
      config_we   <= '0;
      config_data <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      cfg_err     <= 1'b0;
      rdSel       <= '0;
      rdField     <= FLD_MODE;
      rdInRange   <= 1'b0;
    end else begin
      config_we <= '0;
      rd_valid  <= 1'b0;
      cfg_err   <= 1'b0;
      if (accept && cfg_write) begin
        cfg_err <= !inRange;
        if (inRange) begin
          unique case (field)
            FLD_MODE:
              for (int i = 0; i < NUM_REGS; i++)
                if (sel[i]) mode[2*i +: 2] <= cfg_wdata[1:0];
            FLD_CONST:
              for (int i = 0; i < NUM_REGS; i++)
                if (sel[i]) const_[WIDTH*i +: WIDTH] <= cfg_wdata;
            FLD_VALUE: begin
              config_data <= cfg_wdata;
              config_we   <= sel;
            end
            FLD_RSVD: ;
          endcase
        end
      end
      if (accept && !cfg_write) begin
        rdSel     <= sel;
        rdField   <= field;
        rdInRange <= inRange;
      end
      if (state == RD) begin
        rd_valid <= 1'b1;
        rd_data  <= rdMux;
        cfg_err  <= !rdInRange;
      end
    end
  end

endmodule

// File: tb/tb_register_mode_cfg_ctrl.sv
// Randomised bench for register_mode_cfg_ctrl against an
// array-based model of the slice bank (5 slices, so bad indices exist).
module tb_register_mode_cfg_ctrl;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int IW = 3;
  localparam int AW = IW + 2;

  logic           CLK = 1'b0;
  logic           ASYNCRESET;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_write;
  logic [AW-1:0]  cfg_addr;
  logic [W-1:0]   cfg_wdata;
  logic           rd_valid;
  logic [W-1:0]   rd_data;
  logic           cfg_err;
  logic [2*N-1:0] mode;
  logic [W*N-1:0] const_;
  logic [N-1:0]   config_we;
  logic [W-1:0]   config_data;
  logic [W*N-1:0] slice_value;

  int nChecks = 0;
  int nErrors = 0;

  logic [1:0]   mMode [N];
  logic [W-1:0] mConst[N];
  logic [W-1:0] mData;

  register_mode_cfg_ctrl #(
    .NUM_REGS  (N),
    .WIDTH     (W),
    .MODE_RESET(2'h0)
  ) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_write  (cfg_write),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .cfg_err    (cfg_err),
    .mode       (mode),
    .const_     (const_),
    .config_we  (config_we),
    .config_data(config_data),
    .slice_value(slice_value)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic modelReset;
    for (int i = 0; i < N; i++) begin
      mMode[i]  = 2'h0;
      mConst[i] = '0;
    end
    mData = '0;
  endtask

  function automatic logic [31:0] expMode();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v = v | (32'(mMode[i]) << (2 * i));
    return v;
  endfunction

  function automatic logic [31:0] expConst();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v = v | (32'(mConst[i]) << (W * i));
    return v;
  endfunction

  task automatic junkDrive(input bit junk);
    cfg_valid = junk;
    cfg_write = 1'($urandom);
    cfg_addr  = AW'($urandom);
    cfg_wdata = W'($urandom);
  endtask

  task automatic checkBank(input string tag);
    check({tag, "_mode"}, 32'(mode), expMode());
    check({tag, "_const"}, 32'(const_), expConst());
  endtask

  task automatic doWrite(input int idx, input int fld,
                         input logic [W-1:0] d, input bit junk);
    logic [N-1:0] expWe;
    bit good;
    good  = idx < N;
    expWe = '0;
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = AW'(idx * 4 + fld);
    cfg_wdata = d;
    check("wr_ready_idle", 32'(cfg_ready), 32'd1);
    if (good) begin
      case (fld)
        0: mMode[idx] = d[1:0];
        1: mConst[idx] = d;
        2: begin mData = d; expWe[idx] = 1'b1; end
        default: ;
      endcase
    end
    tick;
    junkDrive(junk);
    check("wr_ready_busy", 32'(cfg_ready), 32'd0);
    check("wr_we", 32'(config_we), 32'(expWe));
    check("wr_data", 32'(config_data), 32'(mData));
    check("wr_err", 32'(cfg_err), 32'(!good));
    check("wr_rdvalid", 32'(rd_valid), 32'd0);
    checkBank("wr_t1");
    tick;
    cfg_valid = 1'b0;
    check("wr_we_after", 32'(config_we), 32'd0);
    check("wr_err_after", 32'(cfg_err), 32'd0);
    check("wr_ready_back", 32'(cfg_ready), 32'd1);
    check("wr_data_hold", 32'(config_data), 32'(mData));
    checkBank("wr_t2");
  endtask

  task automatic doRead(input int idx, input int fld,
                        input logic [W*N-1:0] sv, input bit junk);
    logic [W-1:0] exp;
    bit good;
    good = idx < N;
    slice_value = W*N'($urandom);
    cfg_valid = 1'b1;
    cfg_write = 1'b0;
    cfg_addr  = AW'(idx * 4 + fld);
    cfg_wdata = W'($urandom);
    check("rd_ready_idle", 32'(cfg_ready), 32'd1);
    tick;
    junkDrive(junk);
    slice_value = sv;
    exp = '0;
    if (good) begin
      case (fld)
        0: exp = W'(mMode[idx]);
        1: exp = mConst[idx];
        2: exp = sv[W*idx +: W];
        default: exp = '0;
      endcase
    end
    check("rd_ready_busy", 32'(cfg_ready), 32'd0);
    check("rd_early_valid", 32'(rd_valid), 32'd0);
    check("rd_early_err", 32'(cfg_err), 32'd0);
    tick;
    slice_value = W*N'($urandom);
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_data", 32'(rd_data), 32'(exp));
    check("rd_err", 32'(cfg_err), 32'(!good));
    check("rd_ready_resp", 32'(cfg_ready), 32'd0);
    check("rd_we", 32'(config_we), 32'd0);
    tick;
    cfg_valid = 1'b0;
    check("rd_valid_after", 32'(rd_valid), 32'd0);
    check("rd_err_after", 32'(cfg_err), 32'd0);
    check("rd_ready_back", 32'(cfg_ready), 32'd1);
    checkBank("rd_t3");
  endtask

  initial begin
    ASYNCRESET  = 1'b1;
    cfg_valid   = 1'b0;
    cfg_write   = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    slice_value = '0;
    modelReset();
    #2;
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_we", 32'(config_we), 32'd0);
    check("rst_data", 32'(config_data), 32'd0);
    check("rst_rdvalid", 32'(rd_valid), 32'd0);
    check("rst_rddata", 32'(rd_data), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    checkBank("rst");
    #2 ASYNCRESET = 1'b0;
    tick;

    doWrite(2, 0, 4'h1, 1'b0);
    doWrite(1, 2, 4'hA, 1'b0);
    doWrite(0, 0, 4'hF, 1'b0);
    doWrite(4, 1, 4'h9, 1'b0);
    doWrite(3, 3, 4'h5, 1'b0);
    doRead(3, 2, 20'h07000, 1'b0);
    doRead(2, 0, 20'h12345, 1'b0);
    doRead(4, 1, 20'h0, 1'b0);
    doWrite(5, 2, 4'h6, 1'b0);
    doWrite(7, 0, 4'h3, 1'b0);
    doRead(6, 1, 20'hFFFFF, 1'b0);
    doRead(1, 3, 20'hABCDE, 1'b0);

    for (int k = 0; k < 80; k++) begin
      int idx, fld, gap;
      bit junk;
      idx  = int'($urandom_range(0, 7));
      fld  = int'($urandom_range(0, 3));
      junk = 1'($urandom);
      if ($urandom_range(0, 1) == 0)
        doWrite(idx, fld, W'($urandom), junk);
      else
        doRead(idx, fld, W*N'($urandom), junk);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick;
    end

    doWrite(3, 0, 4'h2, 1'b0);
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = AW'(0 * 4 + 2);
    cfg_wdata = 4'hC;
    tick;
    cfg_valid = 1'b0;
    check("mid_we", 32'(config_we), 32'd1);
    #2 ASYNCRESET = 1'b1;
    #1;
    modelReset();
    check("mid_rst_we", 32'(config_we), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_data", 32'(config_data), 32'd0);
    checkBank("mid_rst");
    #2 ASYNCRESET = 1'b0;
    tick;
    check("post_rst_we", 32'(config_we), 32'd0);
    check("post_rst_rdvalid", 32'(rd_valid), 32'd0);
    check("post_rst_err", 32'(cfg_err), 32'd0);
    check("post_rst_ready", 32'(cfg_ready), 32'd1);
    checkBank("post_rst");
    doRead(0, 1, 20'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
